// File: rtl/oiia_sound_sequencer.sv
// 1-bit square-wave sequencer for the looping O-I-I-A jingle. Pitch is counted in
// scanlines and the envelope is applied as pixel-rate PWM.
module oiia_sound_sequencer #(
   parameter int STEP_FRAMES = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [9:0] x,
   input  logic [9:0] y,
   input  logic       mute,
   output logic       sound,
   output logic [2:0] step,
   output logic       note_on
);

   typedef enum logic {
      MUTED = 1'b0,
      PLAY  = 1'b1
   } state_t;

   localparam logic [3:0] LAST_FRAME = 4'(STEP_FRAMES - 1);

   state_t     r_state, w_state;
   logic [2:0] r_step, w_step;
   logic [3:0] r_frame_cnt, w_frame_cnt;
   logic [5:0] r_hp_cnt, w_hp_cnt;
   logic       r_tone, w_tone;
   logic       r_sound, r_note_on;

   logic       w_line_tick, w_frame_tick;
   logic [5:0] w_hp, w_hp_next;
   logic [1:0] w_level;
   logic       w_gate, w_sound;

   // Half-period of each step's note, in scanlines; 0 marks the rest.
   function automatic logic [5:0] note_hp(input logic [2:0] s);
      case (s)
         3'd0:    return 6'd60;
         3'd1:    return 6'd45;
         3'd2:    return 6'd45;
         3'd3:    return 6'd36;
         3'd4:    return 6'd60;
         3'd5:    return 6'd45;
         3'd6:    return 6'd36;
         default: return 6'd0;
      endcase
   endfunction

   assign w_line_tick  = (x == 10'd0);
   assign w_frame_tick = w_line_tick && (y == 10'd0);
   assign w_hp         = note_hp(r_step);

   // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
   always_comb begin
      w_state     = r_state;
      w_step      = r_step;
      w_frame_cnt = r_frame_cnt;
      w_hp_cnt    = r_hp_cnt;
      w_tone      = r_tone;
      if (mute || r_state == MUTED) begin
         w_state     = (!mute && w_frame_tick) ? PLAY : MUTED;
         w_step      = 3'd0;
         w_frame_cnt = 4'd0;
         w_hp_cnt    = 6'd0;
         w_tone      = 1'b0;
      end else if (w_frame_tick && r_frame_cnt == LAST_FRAME) begin
         // Step change resets the tone phase and wins over a coincident toggle.
         w_frame_cnt = 4'd0;
         w_step      = r_step + 3'd1;
         w_hp_cnt    = 6'd0;
         w_tone      = 1'b0;
      end else begin
         if (w_frame_tick) begin
            w_frame_cnt = r_frame_cnt + 4'd1;
         end
         if (w_hp == 6'd0) begin
            w_hp_cnt = 6'd0;
            w_tone   = 1'b0;
         end else if (w_line_tick) begin
            if (r_hp_cnt == w_hp - 6'd1) begin
               w_hp_cnt = 6'd0;
               w_tone   = ~r_tone;
            end else begin
               w_hp_cnt = r_hp_cnt + 6'd1;
            end
         end
      end
   end

   // Outputs are derived from the state being loaded, so they line up with step.
   assign w_hp_next = note_hp(w_step);
   assign w_gate    = (w_state == PLAY) && (w_hp_next != 6'd0) && (w_frame_cnt < LAST_FRAME);

   always_comb begin
      if (w_frame_cnt < 4'd2) begin
         w_level = 2'd3;
      end else if (w_frame_cnt < 4'd4) begin
         w_level = 2'd2;
      end else begin
         w_level = 2'd1;
      end
   end

   assign w_sound = w_tone && w_gate && (x[1:0] < w_level);

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= MUTED;
         r_step      <= 3'd0;
         r_frame_cnt <= 4'd0;
         r_hp_cnt    <= 6'd0;
         r_tone      <= 1'b0;
         r_sound     <= 1'b0;
         r_note_on   <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_step      <= w_step;
         r_frame_cnt <= w_frame_cnt;
         r_hp_cnt    <= w_hp_cnt;
         r_tone      <= w_tone;
         r_sound     <= w_sound;
         r_note_on   <= w_gate;
      end
   end

   assign sound   = r_sound;
   assign step    = r_step;
   assign note_on = r_note_on;

endmodule

// File: tb/tb_oiia_sound_sequencer.sv
// Bench for oiia_sound_sequencer: a compressed timing generator drives x/y, a reference
// model feeds a scoreboard queue, and a vector table pins the jingle's corner cases.
module tb_oiia_sound_sequencer;

   localparam int SF = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [9:0] x, y;
   logic       mute;
   logic       sound, note_on;
   logic [2:0] step;

   always #5 clk = ~clk;

   oiia_sound_sequencer #(.STEP_FRAMES(SF)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .x      (x),
      .y      (y),
      .mute   (mute),
      .sound  (sound),
      .step   (step),
      .note_on(note_on)
   );

   typedef struct {
      int         ph;
      int         fr;
      int         yy;
      int         xx;
      logic       e_sound;
      logic       e_note;
      logic [2:0] e_step;
   } sb_t;

   typedef struct {
      int         ph;
      int         fr;
      int         yy;
      int         xx;
      bit         chk_sound;
      logic       e_sound;
      logic       e_note;
      logic [2:0] e_step;
   } vec_t;

   sb_t  sb_q[$];
   vec_t vecs[$];
   int   hits[$];

   int n_checks = 0;
   int n_fail   = 0;

   int phase     = 0;
   int rst_left  = 0;
   bit mute_i    = 1'b0;
   int mute_on_f = -100, mute_on_y = 0, mute_on_x = 0;
   int mute_off_f = -100, mute_off_y = 0, mute_off_x = 0;
   int rst_f = -100, rst_y = 0, rst_x = 0;

   bit m_play;
   int m_step, m_fc, m_hpc;
   bit m_tone;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h want 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input int ph, input int fr, input int yy, input int xx, input bit cs,
                          input logic es, input logic en, input logic [2:0] est);
      vec_t v;
      v.ph = ph; v.fr = fr; v.yy = yy; v.xx = xx;
      v.chk_sound = cs; v.e_sound = es; v.e_note = en; v.e_step = est;
      vecs.push_back(v);
      hits.push_back(0);
   endtask

   function automatic int note_hp(input int s);
      case (s)
         0: return 60;
         1: return 45;
         2: return 45;
         3: return 36;
         4: return 60;
         5: return 45;
         6: return 36;
         default: return 0;
      endcase
   endfunction

   task automatic model_step(input int f, input int yy, input int xx);
      sb_t r;
      bit  lt, ft, gate;
      int  hp, lvl;
      if (!rst_n) begin
         m_play = 1'b0; m_step = 0; m_fc = 0; m_hpc = 0; m_tone = 1'b0;
      end else begin
         lt = (xx == 0);
         ft = lt && (yy == 0);
         if (mute || !m_play) begin
            m_step = 0; m_fc = 0; m_hpc = 0; m_tone = 1'b0;
            m_play = !mute && ft;
         end else if (ft && m_fc == SF - 1) begin
            m_fc = 0; m_step = (m_step + 1) % 8; m_hpc = 0; m_tone = 1'b0;
         end else begin
            if (ft) m_fc++;
            hp = note_hp(m_step);
            if (hp == 0) begin
               m_hpc = 0; m_tone = 1'b0;
            end else if (lt) begin
               if (m_hpc == hp - 1) begin
                  m_hpc = 0; m_tone = !m_tone;
               end else begin
                  m_hpc++;
               end
            end
         end
      end
      hp   = note_hp(m_step);
      gate = m_play && (hp != 0) && (m_fc < SF - 1);
      lvl  = (m_fc < 2) ? 3 : (m_fc < 4) ? 2 : 1;
      r.ph = phase; r.fr = f; r.yy = yy; r.xx = xx;
      r.e_sound = m_tone && gate && ((xx % 4) < lvl);
      r.e_note  = gate;
      r.e_step  = 3'(m_step);
      sb_q.push_back(r);
   endtask

   task automatic drive_cycle(input int f, input int yy, input int xx);
      bit rst_fall;
      @(negedge clk);
      rst_fall = (rst_n === 1'b1) && (rst_left > 0);
      rst_n = (rst_left == 0);
      if (rst_left > 0) rst_left--;
      x = 10'(xx);
      y = 10'(yy);
      mute = mute_i;
      if (rst_fall) begin
         #1;
         check("async_reset_outputs", {3'b0, sound, note_on, step}, 8'd0);
      end
      model_step(f, yy, xx);
   endtask

   task automatic run_frames(input int n_frames, input int n_lines, input int n_pix);
      for (int f = 0; f < n_frames; f++) begin
         for (int yy = 0; yy < n_lines; yy++) begin
            for (int xx = 0; xx < n_pix; xx++) begin
               if (f == mute_on_f && yy == mute_on_y && xx == mute_on_x) mute_i = 1'b1;
               if (f == mute_off_f && yy == mute_off_y && xx == mute_off_x) mute_i = 1'b0;
               if (f == rst_f && yy == rst_y && xx == rst_x) rst_left = 3;
               drive_cycle(f, yy, xx);
            end
         end
      end
   endtask

   // Reset pulse followed by the tail of a frame so the first tick arrives mid-run.
   task automatic start_phase(input int ph, input int n_lines, input int n_pix);
      phase = ph;
      mute_i = 1'b0;
      mute_on_f = -100; mute_off_f = -100; rst_f = -100;
      rst_left = 3;
      for (int i = 0; i < 3; i++) drive_cycle(-2, 5, 5);
      for (int yy = n_lines - 2; yy < n_lines; yy++)
         for (int xx = 0; xx < n_pix; xx++) drive_cycle(-1, yy, xx);
   endtask

   always @(posedge clk) begin
      sb_t r;
      #1;
      if (sb_q.size() > 0) begin
         r = sb_q.pop_front();
         check($sformatf("model p%0d f%0d y%0d x%0d", r.ph, r.fr, r.yy, r.xx),
               {3'b0, sound, note_on, step}, {3'b0, r.e_sound, r.e_note, r.e_step});
         for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].ph == r.ph && vecs[i].fr == r.fr && vecs[i].yy == r.yy && vecs[i].xx == r.xx) begin
               hits[i]++;
               if (vecs[i].chk_sound)
                  check($sformatf("vec%0d sound/note/step", i), {3'b0, sound, note_on, step},
                        {3'b0, vecs[i].e_sound, vecs[i].e_note, vecs[i].e_step});
               else
                  check($sformatf("vec%0d note/step", i), {4'b0, note_on, step},
                        {4'b0, vecs[i].e_note, vecs[i].e_step});
            end
         end
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: run exceeded its time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Phase 1: reset/start, pitch and envelope with 150 lines x 8 pixels per frame.
      add_vec(1, -1, 148, 0, 1, 0, 0, 3'd0);
      add_vec(1, -1, 149, 7, 1, 0, 0, 3'd0);
      add_vec(1,  0,   0, 0, 1, 0, 1, 3'd0);
      add_vec(1,  0,  59, 4, 1, 0, 1, 3'd0);
      add_vec(1,  0,  60, 0, 1, 1, 1, 3'd0);
      add_vec(1,  0,  60, 4, 1, 1, 1, 3'd0);
      add_vec(1,  0,  60, 5, 1, 1, 1, 3'd0);
      add_vec(1,  0,  60, 6, 1, 1, 1, 3'd0);
      add_vec(1,  0,  60, 7, 1, 0, 1, 3'd0);
      add_vec(1,  0, 119, 4, 1, 1, 1, 3'd0);
      add_vec(1,  0, 120, 4, 1, 0, 1, 3'd0);
      add_vec(1,  2,  30, 4, 1, 1, 1, 3'd0);
      add_vec(1,  2,  30, 5, 1, 1, 1, 3'd0);
      add_vec(1,  2,  30, 6, 1, 0, 1, 3'd0);
      add_vec(1,  5,  60, 4, 1, 1, 1, 3'd0);
      add_vec(1,  5,  60, 5, 1, 0, 1, 3'd0);
      add_vec(1,  7,  10, 4, 1, 0, 0, 3'd0);
      add_vec(1, 24,   0, 0, 1, 0, 1, 3'd3);
      add_vec(1, 24,  35, 4, 1, 0, 1, 3'd3);
      add_vec(1, 24,  36, 4, 1, 1, 1, 3'd3);
      add_vec(1, 24,  71, 4, 1, 1, 1, 3'd3);
      add_vec(1, 24,  72, 4, 1, 0, 1, 3'd3);
      // Phase 2: full loop plus one frame, 16 lines x 4 pixels per frame.
      for (int f = 0; f <= 8 * SF; f++) begin
         add_vec(2, f, 0, 0, 0, 0, ((f % SF) != SF - 1) && (((f / SF) % 8) != 7), 3'((f / SF) % 8));
         add_vec(2, f, 8, 1, 0, 0, ((f % SF) != SF - 1) && (((f / SF) % 8) != 7), 3'((f / SF) % 8));
      end
      // Phase 3: mute in frame 3 of step 2, release mid-frame, 64 lines x 4 pixels.
      add_vec(3, 19,  5, 1, 0, 0, 1, 3'd2);
      add_vec(3, 19,  5, 2, 1, 0, 0, 3'd0);
      add_vec(3, 19, 40, 0, 1, 0, 0, 3'd0);
      add_vec(3, 20, 30, 0, 1, 0, 0, 3'd0);
      add_vec(3, 21,  0, 0, 1, 0, 1, 3'd0);
      add_vec(3, 21, 59, 0, 1, 0, 1, 3'd0);
      add_vec(3, 21, 60, 0, 1, 1, 1, 3'd0);
      // Phase 4: async reset during step 4, 64 lines x 4 pixels.
      add_vec(4, 33, 20, 0, 0, 0, 1, 3'd4);
      add_vec(4, 33, 20, 1, 1, 0, 0, 3'd0);
      add_vec(4, 33, 40, 2, 1, 0, 0, 3'd0);
      add_vec(4, 34,  0, 0, 1, 0, 1, 3'd0);
      add_vec(4, 34, 60, 0, 1, 1, 1, 3'd0);

      rst_n = 1'b0;
      mute  = 1'b0;
      x     = 10'd0;
      y     = 10'd0;
      #1;
      check("power_on_reset_outputs", {3'b0, sound, note_on, step}, 8'd0);

      start_phase(1, 150, 8);
      run_frames(25, 150, 8);

      start_phase(2, 16, 4);
      run_frames(8 * SF + 1, 16, 4);

      start_phase(3, 64, 4);
      mute_on_f  = 19; mute_on_y  = 5; mute_on_x  = 2;
      mute_off_f = 20; mute_off_y = 7; mute_off_x = 1;
      run_frames(22, 64, 4);

      start_phase(4, 64, 4);
      rst_f = 33; rst_y = 20; rst_x = 1;
      run_frames(35, 64, 4);

      @(posedge clk);
      #2;
      check("scoreboard_drained", 8'(sb_q.size()), 8'd0);
      for (int i = 0; i < vecs.size(); i++)
         check($sformatf("vec%0d_reached", i), 8'(hits[i]), 8'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
